// File: rtl/i2s_receiver_pkg.sv
// Shared definitions for the I2S receive path.
//   SAMPLE_WIDTH_DEF : default PCM sample width
//   CH_LEFT/CH_RIGHT : LRCLK level encoding of the two channels
//   *_IDX            : bit positions of BCLK/LRCLK/DIN on the 3-bit input bus
//   rx_state_e       : receiver alignment state
package i2s_receiver_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int unsigned BCLK_IDX  = 0;
  localparam int unsigned LRCLK_IDX = 1;
  localparam int unsigned DIN_IDX   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StShift
  } rx_state_e;

endpackage

// File: rtl/i2s_receiver_input_sync.sv
// Synchroniser and edge detector for the three asynchronous I2S lines.
//   clk_25mhz   : system clock
//   reset       : synchronous, active-high
//   i2s_in      : raw {din, lrclk, bclk} bus (indices from the package)
//   lrclk_level : synchronised LRCLK
//   din_level   : synchronised DIN, same pipeline depth as BCLK
//   bclk_rise   : one-cycle strobe, synchronised BCLK went 0 -> 1
//   lr_edge     : one-cycle strobe, synchronised LRCLK changed
module i2s_input_sync
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [2:0] i2s_in,
  output logic       lrclk_level,
  output logic       din_level,
  output logic       bclk_rise,
  output logic       lr_edge
);

  logic [2:0]             stage_q [SYNC_STAGES];
  logic                   bclk_prev_q;
  logic                   lrclk_prev_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic [2:0]             sync_now;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      bclk_prev_q  <= 1'b0;
      lrclk_prev_q <= 1'b0;
      fill_q       <= '0;
    end else begin
      stage_q[0] <= i2s_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      bclk_prev_q  <= stage_q[SYNC_STAGES-1][BCLK_IDX];
      lrclk_prev_q <= stage_q[SYNC_STAGES-1][LRCLK_IDX];
      fill_q       <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_now    = stage_q[SYNC_STAGES-1];
  assign lrclk_level = sync_now[LRCLK_IDX];
  assign din_level   = sync_now[DIN_IDX];

  // Edges are masked until the whole chain holds real samples; otherwise the
  // cleared flops after reset would look like a BCLK rise or LRCLK edge and
  // could start alignment in the middle of a slot.
  assign bclk_rise = fill_q[SYNC_STAGES] & sync_now[BCLK_IDX] & ~bclk_prev_q;
  assign lr_edge   = fill_q[SYNC_STAGES] & (sync_now[LRCLK_IDX] ^ lrclk_prev_q);

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: deserialises BCLK/LRCLK/DIN into 16-bit stereo frames.
//   clk_25mhz    : system clock, all logic on its rising edge
//   reset        : synchronous, active-high
//   i2s_bclk     : I2S bit clock (async, <= clk_25mhz/4)
//   i2s_lrclk    : word select, 0 = left, 1 = right (async)
//   i2s_din      : serial data, MSB first, one BCLK after LRCLK changes (async)
//   left_sample  : last complete left sample
//   right_sample : last complete right sample
//   frame_valid  : one-cycle pulse when both samples update
//   locked       : aligned to LRCLK
//   slot_error   : one-cycle pulse on a short or over-long slot
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned MAX_SLOT     = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk_25mhz,
  input  logic                    reset,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_din,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    frame_valid,
  output logic                    locked,
  output logic                    slot_error
);

  localparam int unsigned     CntW   = $clog2(MAX_SLOT + 1);
  localparam logic [CntW-1:0] SwCnt  = CntW'(SAMPLE_WIDTH);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_SLOT);

  logic [2:0] i2s_bus;
  logic       lrclk_s;
  logic       din_s;
  logic       bclk_rise;
  logic       lr_edge;

  assign i2s_bus = {i2s_din, i2s_lrclk, i2s_bclk};

  i2s_input_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .i2s_in      (i2s_bus),
    .lrclk_level (lrclk_s),
    .din_level   (din_s),
    .bclk_rise   (bclk_rise),
    .lr_edge     (lr_edge)
  );

  rx_state_e               state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                    cur_ch_q, cur_ch_d;
  logic                    end_pending_q, end_pending_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    have_left_q, have_left_d;
  logic                    locked_q, locked_d;
  logic [SAMPLE_WIDTH-1:0] left_sample_q, left_sample_d;
  logic [SAMPLE_WIDTH-1:0] right_sample_q, right_sample_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    slot_error_q, slot_error_d;

  // Slot-closing datapath. With slots of exactly SAMPLE_WIDTH bits the LSB
  // arrives on the closing rise itself, so that bit still belongs to the
  // closing slot whenever the sample is not yet full.
  logic                    take_bit;
  logic                    closing;
  logic [SAMPLE_WIDTH-1:0] final_shift;
  logic [CntW-1:0]         final_cnt;
  logic [SAMPLE_WIDTH-1:0] closed_val;

  always_comb begin
    take_bit    = (bit_cnt_q < SwCnt);
    closing     = bclk_rise & (end_pending_q | lr_edge);
    final_shift = take_bit ? {shift_q[SAMPLE_WIDTH-2:0], din_s} : shift_q;
    final_cnt   = take_bit ? bit_cnt_q + CntW'(1) : bit_cnt_q;
    closed_val  = (final_cnt < SwCnt) ? (final_shift << (SwCnt - final_cnt)) : final_shift;
  end

  logic err;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    cur_ch_d       = cur_ch_q;
    end_pending_d  = end_pending_q;
    left_hold_d    = left_hold_q;
    have_left_d    = have_left_q;
    locked_d       = locked_q;
    left_sample_d  = left_sample_q;
    right_sample_d = right_sample_q;
    frame_valid_d  = 1'b0;
    slot_error_d   = 1'b0;
    err            = 1'b0;

    case (state_q)
      StIdle: begin
        if (lr_edge) state_d = StArm;
      end
      StArm: begin
        // This rise carries the LSB of a slot we never saw start; drop it.
        if (bclk_rise) begin
          state_d       = StShift;
          shift_d       = '0;
          bit_cnt_d     = '0;
          cur_ch_d      = lrclk_s;
          end_pending_d = 1'b0;
          have_left_d   = 1'b0;
          locked_d      = 1'b1;
        end
      end
      StShift: begin
        if (lr_edge) end_pending_d = 1'b1;
        if (closing) begin
          shift_d       = '0;
          bit_cnt_d     = '0;
          cur_ch_d      = ~cur_ch_q;
          end_pending_d = 1'b0;
          if (final_cnt < SwCnt) begin
            err = 1'b1;
          end else if (cur_ch_q == CH_LEFT) begin
            left_hold_d = closed_val;
            have_left_d = 1'b1;
          end else if (cur_ch_q == CH_RIGHT && have_left_q) begin
            left_sample_d  = left_hold_q;
            right_sample_d = closed_val;
            frame_valid_d  = 1'b1;
            have_left_d    = 1'b0;
          end
        end else if (bclk_rise) begin
          if (take_bit) shift_d = {shift_q[SAMPLE_WIDTH-2:0], din_s};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          // LRCLK stuck: slot longer than MAX_SLOT bit clocks.
          if (bit_cnt_d == MaxCnt) err = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err) begin
      state_d       = StIdle;
      shift_d       = '0;
      bit_cnt_d     = '0;
      end_pending_d = 1'b0;
      have_left_d   = 1'b0;
      locked_d      = 1'b0;
      slot_error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      cur_ch_q       <= CH_LEFT;
      end_pending_q  <= 1'b0;
      left_hold_q    <= '0;
      have_left_q    <= 1'b0;
      locked_q       <= 1'b0;
      left_sample_q  <= '0;
      right_sample_q <= '0;
      frame_valid_q  <= 1'b0;
      slot_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      cur_ch_q       <= cur_ch_d;
      end_pending_q  <= end_pending_d;
      left_hold_q    <= left_hold_d;
      have_left_q    <= have_left_d;
      locked_q       <= locked_d;
      left_sample_q  <= left_sample_d;
      right_sample_q <= right_sample_d;
      frame_valid_q  <= frame_valid_d;
      slot_error_q   <= slot_error_d;
    end
  end

  assign left_sample  = left_sample_q;
  assign right_sample = right_sample_q;
  assign frame_valid  = frame_valid_q;
  assign locked       = locked_q;
  assign slot_error   = slot_error_q;

endmodule
